ps2_key_decoder: RTL and testbench

Turns the raw PS/2 keyboard byte stream into Tetris game commands. Sits directly downstream of the PS/2 frame receiver, whose byte output and frame-complete strobe are both in the PS/2 clock domain. It synchronizes the strobe into the system clock, parses make, break and E0-extended sequences, and tracks held keys. New key presses are queued in a small FIFO that the CPU pops as zero-padded 16-bit memory words.

---
 rtl/ps2_key_decoder_if.sv | 21 ++
 rtl/ps2_key_decoder.sv | 191 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Bundles the scan-code input and the command FIFO port of the PS/2 key decoder.
// The slave side is the decoder; the master side is whatever feeds bytes and pops commands.
interface ps2_key_decoder_if;
  logic [7:0]  ps2_data;
  logic        ps2_frame_clk;
  logic        cmd_ready;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic [4:0]  key_held;
  logic        overflow;

  modport master (
    output ps2_data, ps2_frame_clk, cmd_ready,
    input  cmd_word, cmd_valid, key_held, overflow
  );

  modport slave (
    input  ps2_data, ps2_frame_clk, cmd_ready,
    output cmd_word, cmd_valid, key_held, overflow
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code to Tetris command decoder.
// Synchronizes the receiver's frame strobe, parses make/break/E0 sequences,
// tracks held keys and queues new presses in a small command FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  ps2_key_decoder_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // Base (single-byte) scan codes to command value; 0 = not a game key
  function automatic logic [2:0] base_code(input logic [7:0] b);
    logic [2:0] c;
    c = 3'd0;
    case (b)
      8'h1C:   c = 3'd1;
      8'h23:   c = 3'd2;
      8'h1D:   c = 3'd3;
      8'h1B:   c = 3'd4;
      8'h29:   c = 3'd5;
      default: c = 3'd0;
    endcase
    return c;
  endfunction

  // E0-extended scan codes to command value; 0 = not a game key
  function automatic logic [2:0] ext_code(input logic [7:0] b);
    logic [2:0] c;
    c = 3'd0;
    case (b)
      8'h6B:   c = 3'd1;
      8'h74:   c = 3'd2;
      8'h75:   c = 3'd3;
      8'h72:   c = 3'd4;
      default: c = 3'd0;
    endcase
    return c;
  endfunction

  // Keyboard status/response bytes that can never be part of a key sequence
  function automatic logic is_abort(input logic [7:0] b);
    logic a;
    case (b)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: a = 1'b1;
      default:                                         a = 1'b0;
    endcase
    return a;
  endfunction

  // Command value to its key_held bit
  function automatic logic [4:0] cmd_mask(input logic [2:0] c);
    logic [4:0] m;
    case (c)
      3'd1:    m = 5'b00001;
      3'd2:    m = 5'b00010;
      3'd3:    m = 5'b00100;
      3'd4:    m = 5'b01000;
      3'd5:    m = 5'b10000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  logic          s1, s2, s3;
  logic          byte_evt;
  logic          byte_pulse;
  logic [7:0]    byte_r;

  state_t        state, state_nxt;
  logic [2:0]    make_cmd, brk_cmd;
  logic [4:0]    key_held_r;
  logic          push_req;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          full, empty, pop, do_push;
  logic          overflow_r;

  // Strobe synchronizer; preset to 1 so a strobe already high at reset is not seen as an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      byte_pulse <= 1'b0;
    end else begin
      s1 <= bus.ps2_frame_clk;
      s2 <= s1;
      s3 <= s2;
      byte_pulse <= byte_evt;
    end
  end

  assign byte_evt = s2 & ~s3;

  // Capture the scan-code byte; the receiver holds it stable long after the strobe
  always_ff @(posedge clk) begin
    if (byte_evt) byte_r <= bus.ps2_data;
  end

  // Decode the current byte against the parser state into next state and make/break events
  always_comb begin
    state_nxt = state;
    make_cmd  = 3'd0;
    brk_cmd   = 3'd0;
    if (byte_pulse) begin
      if (is_abort(byte_r)) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (byte_r == 8'hE0)      state_nxt = EXT;
            else if (byte_r == 8'hF0) state_nxt = BRK;
            else                      make_cmd  = base_code(byte_r);
          end
          EXT: begin
            if (byte_r == 8'hF0) begin
              state_nxt = EXT_BRK;
            end else begin
              make_cmd  = ext_code(byte_r);
              state_nxt = IDLE;
            end
          end
          BRK: begin
            brk_cmd   = base_code(byte_r);
            state_nxt = IDLE;
          end
          EXT_BRK: begin
            brk_cmd   = ext_code(byte_r);
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Only the first make of a key queues a command; typematic repeats are absorbed
  assign push_req = (make_cmd != 3'd0) && ((key_held_r & cmd_mask(make_cmd)) == 5'b00000);

  // Parser state and held-key bitmap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      key_held_r <= 5'b00000;
    end else begin
      state      <= state_nxt;
      key_held_r <= (key_held_r | cmd_mask(make_cmd)) & ~cmd_mask(brk_cmd);
    end
  end

  assign empty   = (wptr == rptr);
  assign full    = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
  assign pop     = bus.cmd_ready & ~empty;
  assign do_push = push_req & (~full | pop);

  // FIFO pointers and sticky overflow; a pop frees the slot for a same-cycle push when full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push)                  wptr       <= wptr + 1'b1;
      if (pop)                      rptr       <= rptr + 1'b1;
      if (push_req & full & ~pop)   overflow_r <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= make_cmd;
  end

  assign bus.cmd_valid = ~empty;
  assign bus.cmd_word  = empty ? 16'h0000 : {13'b0, mem[rptr[AW-1:0]]};
  assign bus.key_held  = key_held_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: scan-code sequences with hand-computed results.
module tb_ps2_key_decoder;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One receiver frame: strobe high for 6 cycles, optional pop on the push edge (A+3)
  task automatic send_byte(input logic [7:0] b, input logic pop_at_push);
    @(negedge clk);
    bus.ps2_data      = b;
    bus.ps2_frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    if (pop_at_push) bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.ps2_frame_clk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0] keys [5];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ps2_data      = 8'h00;
    bus.ps2_frame_clk = 1'b0;
    bus.cmd_ready     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid",    16'(bus.cmd_valid), 16'h0000);
    chk("rst_word",     bus.cmd_word,       16'h0000);
    chk("rst_held",     16'(bus.key_held),  16'h0000);
    chk("rst_overflow", 16'(bus.overflow),  16'h0000);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Left press E0 6B with latency check
    send(8'hE0);
    @(negedge clk);
    bus.ps2_data      = 8'h6B;
    bus.ps2_frame_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("lat_A2_valid", 16'(bus.cmd_valid), 16'h0000);
    @(posedge clk);
    #1 chk("lat_A3_valid", 16'(bus.cmd_valid), 16'h0001);
    chk("left_word", bus.cmd_word,      16'h0001);
    chk("left_held", 16'(bus.key_held), 16'h0001);
    repeat (3) @(negedge clk);
    bus.ps2_frame_clk = 1'b0;
    repeat (6) @(negedge clk);
    pop_one();
    chk("left_pop_valid", 16'(bus.cmd_valid), 16'h0000);
    chk("left_pop_word",  bus.cmd_word,       16'h0000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("left_rel_held", 16'(bus.key_held), 16'h0000);

    // Typematic repeats of space then break
    send(8'h29);
    chk("space_held", 16'(bus.key_held), 16'h0010);
    send(8'h29); send(8'h29);
    chk("space_word", bus.cmd_word, 16'h0005);
    pop_one();
    chk("space_one_entry", 16'(bus.cmd_valid), 16'h0000);
    send(8'hF0); send(8'h29);
    chk("space_rel_held", 16'(bus.key_held), 16'h0000);

    // Extended break and aborted prefix
    send(8'hE0); send(8'h74);
    chk("right_word", bus.cmd_word, 16'h0002);
    pop_one();
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("right_rel_held",  16'(bus.key_held),  16'h0000);
    chk("right_rel_valid", 16'(bus.cmd_valid), 16'h0000);
    send(8'hE0); send(8'hAA); send(8'h1D);
    chk("abort_then_w", bus.cmd_word, 16'h0003);
    pop_one();
    send(8'hF0); send(8'h1D);

    // Overflow: five press/release pairs, no pops
    keys[0] = 8'h1C; keys[1] = 8'h23; keys[2] = 8'h1D; keys[3] = 8'h1B; keys[4] = 8'h29;
    for (int i = 0; i < 5; i++) begin
      send(keys[i]); send(8'hF0); send(keys[i]);
    end
    chk("ovf_flag", 16'(bus.overflow), 16'h0001);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", bus.cmd_word, 16'(i));
      pop_one();
    end
    chk("ovf_drained",  16'(bus.cmd_valid), 16'h0000);
    chk("ovf_sticky",   16'(bus.overflow),  16'h0001);

    // Full FIFO with pop and push on the same edge
    do_reset();
    chk("post_rst_ovf", 16'(bus.overflow), 16'h0000);
    for (int i = 0; i < 4; i++) send(keys[i]);
    send_byte(8'h29, 1'b1);
    chk("simul_ovf",  16'(bus.overflow), 16'h0000);
    chk("simul_held", 16'(bus.key_held), 16'h001F);
    for (int i = 2; i <= 5; i++) begin
      chk("simul_order", bus.cmd_word, 16'(i));
      pop_one();
    end
    chk("simul_drained", 16'(bus.cmd_valid), 16'h0000);

    // Empty FIFO with cmd_ready high during the push
    send(8'hF0); send(8'h1C);
    send_byte(8'h1C, 1'b1);
    chk("empty_rdy_valid", 16'(bus.cmd_valid), 16'h0001);
    chk("empty_rdy_word",  bus.cmd_word,       16'h0001);
    pop_one();

    // Reset between E0 and 6B while the strobe is high
    send(8'hF0); send(8'h23); send(8'h23);
    send(8'hF0); send(8'h1D); send(8'h1D);
    chk("pre_rst_word", bus.cmd_word, 16'h0002);
    send(8'hE0);
    @(negedge clk);
    bus.ps2_data      = 8'h6B;
    bus.ps2_frame_clk = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(bus.cmd_valid), 16'h0000);
    chk("mid_rst_word",  bus.cmd_word,       16'h0000);
    chk("mid_rst_held",  16'(bus.key_held),  16'h0000);
    chk("mid_rst_ovf",   16'(bus.overflow),  16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    bus.ps2_frame_clk = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_spur_valid", 16'(bus.cmd_valid), 16'h0000);
    chk("no_spur_held",  16'(bus.key_held),  16'h0000);
    send(8'h6B);
    chk("lost_prefix_valid", 16'(bus.cmd_valid), 16'h0000);
    chk("lost_prefix_held",  16'(bus.key_held),  16'h0000);
    send(8'h1C);
    chk("after_rst_word", bus.cmd_word, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
